// File: rtl/tcore_param.sv
// Shared lowX bus types: request/response structs and the access-size encoding.
package tcore_param;

  localparam int unsigned LOWX_XLEN     = 32;
  localparam int unsigned LOWX_BLK_SIZE = 128;

  typedef enum logic [1:0] {
    WORD      = 2'd0,
    HALF_WORD = 2'd1,
    BYTE      = 2'd2,
    NO_SIZE   = 2'd3
  } memory_operation_size_t;

  typedef struct packed {
    logic                         valid;
    logic                         ready;
    logic [LOWX_XLEN-1:0]         addr;
    logic                         uncached;
    logic                         rw;
    memory_operation_size_t       rw_size;
    logic [LOWX_BLK_SIZE-1:0]     data;
  } lowX_req_t;

  typedef struct packed {
    logic                         valid;
    logic                         ready;
    logic [LOWX_BLK_SIZE-1:0]     data;
  } lowX_res_t;

endpackage

// File: rtl/sp_bram.sv
// Single-port block RAM with registered read data; contents are never reset.
module sp_bram #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NUM_SETS   = 1024
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic                        we,
  input  logic [$clog2(NUM_SETS)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic [DATA_WIDTH-1:0]       rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_SETS];

  // rdata only changes on an enabled read, so it holds the last line read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/lowx_mem_responder.sv
// Fixed-latency lowX memory responder: one request in flight, line reads/writes and
// read-modify-write for uncached sub-line stores.
module lowx_mem_responder #(
  parameter int unsigned MEM_LINES = 1024,
  parameter int unsigned BLK_SIZE  = 128,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned LATENCY   = 4,
  parameter type lowX_req_t = tcore_param::lowX_req_t,
  parameter type lowX_res_t = tcore_param::lowX_res_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  lowX_req_t lowX_req_i,
  output lowX_res_t lowX_res_o
);

  import tcore_param::*;

  localparam int unsigned BlkOffset = $clog2(BLK_SIZE / 8);
  localparam int unsigned IdxWidth  = $clog2(MEM_LINES);
  localparam int unsigned AddrWidth = BlkOffset + IdxWidth;
  localparam int unsigned CntWidth  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;

  logic [IdxWidth-1:0]    idx_q;
  logic [BlkOffset-1:0]   off_q;
  logic                   unc_q;
  logic                   rw_q;
  memory_operation_size_t size_q;
  logic [BLK_SIZE-1:0]    data_q;

  logic                   accept;
  logic                   first_wait;
  logic                   last_wait;
  logic                   mem_en;
  logic                   mem_we;
  logic [BLK_SIZE-1:0]    rdata;
  logic [BLK_SIZE-1:0]    wline;

  // Address bits above the line index alias onto the same storage.
  logic unused_addr;
  assign unused_addr = ^lowX_req_i.addr[XLEN-1:AddrWidth];

  assign accept = (state_q == StIdle) && lowX_req_i.valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q  <= lowX_req_i.addr[AddrWidth-1:BlkOffset];
      off_q  <= lowX_req_i.addr[BlkOffset-1:0];
      unc_q  <= lowX_req_i.uncached;
      rw_q   <= lowX_req_i.rw;
      size_q <= lowX_req_i.rw_size;
      data_q <= lowX_req_i.data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          cnt_d   = CntWidth'(LATENCY - 1);
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (lowX_req_i.ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read the line on the first wait cycle; commit any write on the last one so that a
  // reset earlier in the wait leaves memory untouched.
  assign first_wait = (state_q == StWait) && (cnt_q == CntWidth'(LATENCY - 1));
  assign last_wait  = (state_q == StWait) && (cnt_q == '0);
  assign mem_we     = last_wait && rw_q && !(unc_q && (size_q == NO_SIZE));
  assign mem_en     = first_wait || mem_we;

  always_comb begin
    wline = rdata;
    if (!unc_q) begin
      wline = data_q;
    end else begin
      unique case (size_q)
        WORD:      wline[{off_q[BlkOffset-1:2], 5'b0} +: 32] = data_q[31:0];
        HALF_WORD: wline[{off_q[BlkOffset-1:1], 4'b0} +: 16] = data_q[15:0];
        BYTE:      wline[{off_q, 3'b0} +: 8]                 = data_q[7:0];
        NO_SIZE:   wline = rdata;
        default:   wline = rdata;
      endcase
    end
  end

  sp_bram #(
    .DATA_WIDTH (BLK_SIZE),
    .NUM_SETS   (MEM_LINES)
  ) u_bram (
    .clk   (clk_i),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (wline),
    .rdata (rdata)
  );

  always_comb begin
    lowX_res_o       = '0;
    lowX_res_o.ready = (state_q == StIdle) && !rst_i;
    if (state_q == StResp) begin
      lowX_res_o.valid = 1'b1;
      if (!rw_q) begin
        lowX_res_o.data = rdata;
      end
    end
  end

endmodule
